pipe_stage_chain: RTL
=====================

# pipe_stage_chain

Parametrised multi-stage pipeline register chain. It replaces single flush-only pipeline registers between CPU stages with a configurable-depth chain, and adds:
- per-stage valid bits;
- per-stage stall (hold) with automatic upstream back-pressure and bubble insertion;
- per-stage flush;
- a saturating stall-cycle counter for the hazard unit and performance reporting.

It sits between the hazard detection unit and the datapath stage boundaries (IF/ID through MEM/WB).

## Interface
Parameters:
- WIDTH, 32, payload bits per stage (≥1)
- DEPTH, 1, number of register stages (≥1)
- CNT_W, 16, width of stall-cycle counter (≥1)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_i  in  1  input payload valid
- data_i  in  WIDTH  input payload
- ready_o  out  1  stage 0 will load this cycle (not holding)
- stall_i  in  DEPTH  bit k holds stage k (and all upstream stages)
- flush_i  in  DEPTH  bit k clears stage k at next edge
- cnt_clr_i  in  1  synchronous clear of stall counter
- data_o  out  WIDTH  payload of stage DEPTH-1
- valid_o  out  1  valid of stage DEPTH-1
- stage_valid_o  out  DEPTH  valid bit of every stage, bit k = stage k
- stall_cnt_o  out  CNT_W  saturating count of cycles with ready_o=0

## Operation
- State per stage k: v[k] (1 bit) and d[k] (WIDTH bits). Stage 0 is nearest the input.
- Hold term: h[k] = OR of stall_i[j] for j = k..DEPTH-1. A stall at stage k freezes stage k and every upstream stage.
- Per-stage next state, first matching rule wins:
  1. flush_i[k]=1: v[k]←0, d[k]←0. Flush beats stall.
  2. h[k]=1: hold v[k], d[k].
  3. k>0 and h[k-1]=1 (i.e. stall_i[k-1]=1): bubble, v[k]←0, d[k]←0.
  4. Otherwise load. k=0: v←valid_i, d←data_i. k>0: v←v[k-1], d←d[k-1].
- Flush is independent per stage. It does not propagate up or down; the hazard unit asserts every bit it needs.
- Invalid data is never forced to zero except by rules 1 and 3. With valid_i=0, d[0] still loads data_i.
- ready_o = ~h[0], purely combinational from stall_i. An input is accepted when valid_i & ready_o & ~flush_i[0]. A flushed stage 0 discards the input.
- Stall counter:
  - cnt_clr_i=1: counter←0. Clear beats increment.
  - Else if ready_o=0 and counter < 2^CNT_W-1: counter+1.
  - At all-ones it saturates and holds.
- DEPTH=1 with stall_i=0 behaves exactly like the legacy flush-only pipeline register.

## Timing
- Reset (rst_n=0, asynchronous): all v[k]=0, d[k]=0, stall_cnt_o=0. Therefore data_o=0, valid_o=0, stage_valid_o=0.
- ready_o during reset follows stall_i. Registers ignore clk_i while rst_n=0.
- Reset deassertion mid-operation: the chain restarts empty. The first load happens on the first rising edge with rst_n=1.
- Latency with no stall/flush: DEPTH cycles from data_i to data_o. Throughput is one item per cycle.
- Stall on stage k held for N cycles inserts exactly N bubbles into stage k+1 (k<DEPTH-1). No item is duplicated or lost.
- Stall on the last stage: data_o/valid_o hold. No bubble is emitted (no downstream stage).
- Simultaneous stall_i[k] and flush_i[k]: stage k clears. Upstream stages still hold (h is unaffected by flush). Stage k+1 receives a bubble.
- Simultaneous flush_i[k] and rule 3 on stage k: result is identical (cleared).
- All outputs except ready_o are registered. ready_o has zero latency.

## Test plan
1. Reset/fill (WIDTH=8, DEPTH=3): assert rst_n=0 mid-stream → all outputs 0 immediately. Release, drive valid_i=1 with data 0x11,0x22,0x33 on consecutive cycles → data_o=0x11, valid_o=1 on the 3rd edge after first drive, then 0x22, 0x33.
2. Mid stall: chain full with 0xA1 (st2), 0xA2 (st1), 0xA3 (st0); assert stall_i=3'b010 for 2 cycles →
   - ready_o=0; stages 0 and 1 hold 0xA3/0xA2;
   - data_o outputs 0xA1, then bubble (valid 0) for 2 cycles;
   - then 0xA2, 0xA3 after release.
3. Flush vs stall: stall_i=3'b001, flush_i=3'b001 same cycle on stage 0 holding 0x5C → stage 0 clears (v=0, d=0). Stage 1 gets a bubble. ready_o=0 that cycle.
4. Single-stage legacy equivalence (DEPTH=1): random data_i with random flush_i[0], stall_i=0 → data_o equals data_i delayed one cycle, or 0 the cycle after flush.
5. Counter (CNT_W=2): hold stall_i[0]=1 for 5 cycles → stall_cnt_o 1,2,3,3,3. Assert cnt_clr_i with stall still high → 0 next edge, then 1.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: configurable-depth chain of pipeline registers with
// per-stage valid bits, stall with upstream back-pressure and bubble
// insertion, per-stage flush, and a saturating stall-cycle counter.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_n         asynchronous active-low reset
//   valid_i       input payload valid
//   data_i        input payload (WIDTH)
//   ready_o       stage 0 loads this cycle (combinational from stall_i)
//   stall_i       bit k holds stage k and every upstream stage (DEPTH)
//   flush_i       bit k clears stage k at the next edge (DEPTH)
//   cnt_clr_i     synchronous clear of the stall counter
//   data_o        payload of the last stage (WIDTH)
//   valid_o       valid of the last stage
//   stage_valid_o valid bit of every stage, bit k = stage k (DEPTH)
//   stall_cnt_o   saturating count of cycles with ready_o low (CNT_W)
module pipe_stage_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic [DEPTH-1:0] stall_i,
  input  logic [DEPTH-1:0] flush_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [DEPTH-1:0] stage_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [DEPTH-1:0]            hold;
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // hold[k] is the OR of stall_i from stage k down to the last stage.
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = stall_i[DEPTH-1];
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      hold[k] = stall_i[k] | hold[k+1];
    end
  end

  assign ready_o = ~hold[0];

  always_comb begin
    v_d = v_q;
    d_d = d_q;

    // Stage 0: flush beats hold; otherwise load the input unconditionally
    // (data loads even when valid_i is low).
    if (flush_i[0]) begin
      v_d[0] = 1'b0;
      d_d[0] = '0;
    end else if (!hold[0]) begin
      v_d[0] = valid_i;
      d_d[0] = data_i;
    end

    for (int k = 1; k < int'(DEPTH); k++) begin
      if (flush_i[k]) begin
        v_d[k] = 1'b0;
        d_d[k] = '0;
      end else if (hold[k]) begin
        v_d[k] = v_q[k];
        d_d[k] = d_q[k];
      end else if (stall_i[k-1]) begin
        // Upstream neighbour is frozen while this stage drains: insert a bubble.
        v_d[k] = 1'b0;
        d_d[k] = '0;
      end else begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (!ready_o && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o        = d_q[DEPTH-1];
  assign valid_o       = v_q[DEPTH-1];
  assign stage_valid_o = v_q;
  assign stall_cnt_o   = cnt_q;

endmodule
